// File: rtl/ram_arbiter_pkg.sv
// Shared constants for the RAM arbiter: owner encoding and grant counter width.
package ram_arbiter_pkg;

  localparam int CNT_W = 16;

  // lastOwner encoding
  localparam logic [1:0] OWNER_NONE = 2'd0;
  localparam logic [1:0] OWNER_CPU  = 2'd1;
  localparam logic [1:0] OWNER_DBG  = 2'd2;

endpackage

// File: rtl/ram_arbiter_saturating_counter.sv
// Grant counter that sticks at all-ones instead of wrapping.
module saturating_counter
  import ram_arbiter_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: step by one on enable unless already saturated
  always_comb begin
    count_d = count_q;
    if (en && (count_q != {CNT_W{1'b1}})) count_d = count_q + 1'b1;
  end

  // Count register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter (CPU read/write, debug read-only) in front of a synchronous
// single-port RAM. CPU has priority; debug is guaranteed a slot after
// STARVE_LIMIT consecutive CPU wins while it waits.
//
// lastOwner | meaning
// ----------+------------------------------------------
// NONE      | previous cycle had no grant
// CPU       | previous cycle granted the CPU port
// DBG       | previous cycle granted the debug port
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpuReq,
  input  logic              cpuStore,
  input  logic [ADDR_W-1:0] cpuAddress,
  input  logic [31:0]       cpuData,
  output logic              cpuGrant,
  output logic              cpuValid,
  output logic              cpuStall,
  input  logic              dbgReq,
  input  logic [ADDR_W-1:0] dbgAddress,
  output logic              dbgGrant,
  output logic              dbgValid,
  output logic [31:0]       readData,
  output logic              ramStore,
  output logic [ADDR_W-1:0] ramAddress,
  output logic [31:0]       ramData,
  input  logic [31:0]       ramResult,
  output logic [CNT_W-1:0]  cpuCount,
  output logic [CNT_W-1:0]  dbgCount,
  output logic [1:0]        lastOwner
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [3:0]        starve_q, starve_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        owner_q, owner_d;
  logic              cpu_valid_q, cpu_valid_d;
  logic              dbg_valid_q, dbg_valid_d;
  logic              cpu_grant, dbg_grant, dbg_priority;

  // Grant decision; reset kills grants immediately so nothing reaches the RAM
  always_comb begin
    dbg_priority = dbgReq && (starve_q == STARVE_MAX);
    cpu_grant    = !reset && cpuReq && !dbg_priority;
    dbg_grant    = !reset && dbgReq && !cpu_grant;
  end

  // Next-state for starvation counter, address hold, owner and read valids
  always_comb begin
    starve_d = starve_q;
    if (dbg_grant || !dbgReq)                 starve_d = '0;
    else if (cpu_grant && starve_q != STARVE_MAX) starve_d = starve_q + 4'd1;

    if (cpu_grant)      addr_d = cpuAddress;
    else if (dbg_grant) addr_d = dbgAddress;
    else                addr_d = addr_q;

    if (cpu_grant)      owner_d = OWNER_CPU;
    else if (dbg_grant) owner_d = OWNER_DBG;
    else                owner_d = OWNER_NONE;

    cpu_valid_d = cpu_grant && !cpuStore;
    dbg_valid_d = dbg_grant;
  end

  // Arbiter state registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_q    <= '0;
      addr_q      <= '0;
      owner_q     <= OWNER_NONE;
      cpu_valid_q <= 1'b0;
      dbg_valid_q <= 1'b0;
    end else begin
      starve_q    <= starve_d;
      addr_q      <= addr_d;
      owner_q     <= owner_d;
      cpu_valid_q <= cpu_valid_d;
      dbg_valid_q <= dbg_valid_d;
    end
  end

  assign cpuGrant   = cpu_grant;
  assign dbgGrant   = dbg_grant;
  assign cpuStall   = cpuReq && !cpu_grant;
  assign ramStore   = cpuStore && cpu_grant;
  assign ramAddress = addr_d;
  assign ramData    = cpuData;
  assign cpuValid   = cpu_valid_q;
  assign dbgValid   = dbg_valid_q;
  assign readData   = (cpu_valid_q || dbg_valid_q) ? ramResult : 32'h0;
  assign lastOwner  = owner_q;

  saturating_counter u_cpu_cnt (
    .clock (clock),
    .reset (reset),
    .en    (cpu_grant),
    .count (cpuCount)
  );

  saturating_counter u_dbg_cnt (
    .clock (clock),
    .reset (reset),
    .en    (dbg_grant),
    .count (dbgCount)
  );

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural RAM and a read scoreboard.
module tb_ram_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cpuReq = 1'b0, cpuStore = 1'b0;
  logic [9:0]  cpuAddress = '0;
  logic [31:0] cpuData = '0;
  logic        cpuGrant, cpuValid, cpuStall;
  logic        dbgReq = 1'b0;
  logic [9:0]  dbgAddress = '0;
  logic        dbgGrant, dbgValid;
  logic [31:0] readData;
  logic        ramStore;
  logic [9:0]  ramAddress;
  logic [31:0] ramData;
  logic [31:0] ramResult = '0;
  logic [15:0] cpuCount, dbgCount;
  logic [1:0]  lastOwner;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit          is_dbg;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  logic [31:0] mem    [256];
  logic [31:0] shadow [256];

  logic [15:0] exp_cpu_cnt = '0, exp_dbg_cnt = '0;
  logic [1:0]  exp_owner = 2'd0;
  logic [9:0]  exp_last_addr = '0;

  ram_arbiter #(.ADDR_W(10), .STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .cpuReq(cpuReq), .cpuStore(cpuStore), .cpuAddress(cpuAddress), .cpuData(cpuData),
    .cpuGrant(cpuGrant), .cpuValid(cpuValid), .cpuStall(cpuStall),
    .dbgReq(dbgReq), .dbgAddress(dbgAddress),
    .dbgGrant(dbgGrant), .dbgValid(dbgValid),
    .readData(readData),
    .ramStore(ramStore), .ramAddress(ramAddress), .ramData(ramData),
    .ramResult(ramResult),
    .cpuCount(cpuCount), .dbgCount(dbgCount), .lastOwner(lastOwner)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] init_word(input int idx);
    return 32'h1000_0000 + 32'(idx) * 32'h0000_0101;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]    = init_word(i);
      shadow[i] = init_word(i);
    end
  end

  // Synchronous RAM: one-cycle read latency
  always @(posedge clock) begin
    if (ramStore) mem[ramAddress[9:2]] <= ramData;
    ramResult <= mem[ramAddress[9:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Compare registered outputs produced by the previous clock edge
  task automatic sb_check(input string tag);
    logic exp_cv, exp_dv;
    logic [31:0] exp_rd;
    exp_cv = 1'b0; exp_dv = 1'b0; exp_rd = 32'h0;
    if (sb.size() > 0) begin
      exp_cv = !sb[0].is_dbg;
      exp_dv = sb[0].is_dbg;
      exp_rd = sb[0].data;
      void'(sb.pop_front());
    end
    chk({tag, ".cpuValid"}, {31'b0, cpuValid}, {31'b0, exp_cv});
    chk({tag, ".dbgValid"}, {31'b0, dbgValid}, {31'b0, exp_dv});
    chk({tag, ".readData"}, readData, exp_rd);
    chk({tag, ".lastOwner"}, {30'b0, lastOwner}, {30'b0, exp_owner});
    chk({tag, ".cpuCount"}, {16'b0, cpuCount}, {16'b0, exp_cpu_cnt});
    chk({tag, ".dbgCount"}, {16'b0, dbgCount}, {16'b0, exp_dbg_cnt});
  endtask

  // One clock cycle: check last edge's results, drive requests, check grants
  task automatic tick(input bit cr, input bit cs, input logic [9:0] ca, input logic [31:0] cd,
                      input bit dr, input logic [9:0] da, input bit ecg, input bit edg,
                      input string tag);
    logic [9:0] exp_addr;
    @(negedge clock);
    sb_check(tag);
    cpuReq = cr; cpuStore = cs; cpuAddress = ca; cpuData = cd;
    dbgReq = dr; dbgAddress = da;
    #1;
    exp_addr = ecg ? ca : (edg ? da : exp_last_addr);
    chk({tag, ".cpuGrant"}, {31'b0, cpuGrant}, {31'b0, ecg});
    chk({tag, ".dbgGrant"}, {31'b0, dbgGrant}, {31'b0, edg});
    chk({tag, ".cpuStall"}, {31'b0, cpuStall}, {31'b0, cr & ~ecg});
    chk({tag, ".ramStore"}, {31'b0, ramStore}, {31'b0, cs & ecg});
    chk({tag, ".ramAddress"}, {22'b0, ramAddress}, {22'b0, exp_addr});
    if (ecg && cs) chk({tag, ".ramData"}, ramData, cd);
    if (ecg && !cs) sb.push_back('{is_dbg: 1'b0, data: shadow[ca[9:2]]});
    if (ecg && cs)  shadow[ca[9:2]] = cd;
    if (edg)        sb.push_back('{is_dbg: 1'b1, data: shadow[da[9:2]]});
    exp_last_addr = exp_addr;
    exp_owner     = ecg ? 2'd1 : (edg ? 2'd2 : 2'd0);
    if (ecg) exp_cpu_cnt = sat_inc(exp_cpu_cnt);
    if (edg) exp_dbg_cnt = sat_inc(exp_dbg_cnt);
  endtask

  task automatic idle(input string tag);
    tick(0, 0, 10'h000, 32'h0, 0, 10'h000, 0, 0, tag);
  endtask

  task automatic model_reset();
    exp_cpu_cnt = '0; exp_dbg_cnt = '0; exp_owner = 2'd0; exp_last_addr = '0;
    sb.delete();
  endtask

  initial begin
    // Reset with a CPU request already pending
    cpuReq = 1'b1;
    #1 reset = 1'b1;
    #2;
    chk("rst.cpuGrant",   {31'b0, cpuGrant}, 32'd0);
    chk("rst.dbgGrant",   {31'b0, dbgGrant}, 32'd0);
    chk("rst.cpuStall",   {31'b0, cpuStall}, 32'd1);
    chk("rst.cpuValid",   {31'b0, cpuValid}, 32'd0);
    chk("rst.dbgValid",   {31'b0, dbgValid}, 32'd0);
    chk("rst.ramStore",   {31'b0, ramStore}, 32'd0);
    chk("rst.ramAddress", {22'b0, ramAddress}, 32'd0);
    chk("rst.readData",   readData, 32'd0);
    chk("rst.counts",     {cpuCount, dbgCount}, 32'd0);
    chk("rst.lastOwner",  {30'b0, lastOwner}, 32'd0);
    cpuReq = 1'b0;
    @(posedge clock); #1 reset = 1'b0;

    // CPU read alone, then write / debug read-back
    tick(1, 0, 10'h010, 32'h0, 0, 10'h000, 1, 0, "cpu_rd");
    tick(1, 1, 10'h020, 32'hDEADBEEF, 0, 10'h000, 1, 0, "cpu_wr");
    tick(0, 0, 10'h000, 32'h0, 1, 10'h020, 0, 1, "dbg_rd");
    idle("idle_hold");
    idle("idle2");

    // Both requesting continuously: CPU x4 then DBG, repeating
    for (int i = 0; i < 10; i++) begin
      bit dslot;
      dslot = (i % 5) == 4;
      tick(1, 0, 10'(32'h100 + 4 * i), 32'h0, 1, 10'(32'h200 + 4 * i),
           !dslot, dslot, $sformatf("starve%0d", i));
    end

    // CPU write stalled behind debug, then cancelled
    for (int i = 0; i < 4; i++)
      tick(1, 0, 10'(32'h300 + 4 * i), 32'h0, 1, 10'h000, 1, 0, $sformatf("pre_cancel%0d", i));
    tick(1, 1, 10'h040, 32'hBAADF00D, 1, 10'h044, 0, 1, "stalled_wr");
    tick(0, 0, 10'h000, 32'h0, 1, 10'h048, 0, 1, "cancel");
    idle("post_cancel");
    tick(1, 0, 10'h040, 32'h0, 0, 10'h000, 1, 0, "rd_cancelled_addr");

    // Build up starvation, then reset during a CPU read grant
    tick(1, 0, 10'h080, 32'h0, 1, 10'h084, 1, 0, "pre_rst0");
    tick(1, 0, 10'h088, 32'h0, 1, 10'h08C, 1, 0, "pre_rst1");
    @(negedge clock);
    sb_check("mid_rst");
    cpuReq = 1'b1; cpuStore = 1'b0; cpuAddress = 10'h0C0; dbgReq = 1'b1; dbgAddress = 10'h0C4;
    #1;
    chk("mid_rst.grant_before", {31'b0, cpuGrant}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst.cpuGrant",   {31'b0, cpuGrant}, 32'd0);
    chk("mid_rst.dbgGrant",   {31'b0, dbgGrant}, 32'd0);
    chk("mid_rst.cpuStall",   {31'b0, cpuStall}, 32'd1);
    chk("mid_rst.ramAddress", {22'b0, ramAddress}, 32'd0);
    chk("mid_rst.ramStore",   {31'b0, ramStore}, 32'd0);
    chk("mid_rst.readData",   readData, 32'd0);
    chk("mid_rst.valids",     {30'b0, cpuValid, dbgValid}, 32'd0);
    chk("mid_rst.counts",     {cpuCount, dbgCount}, 32'd0);
    chk("mid_rst.lastOwner",  {30'b0, lastOwner}, 32'd0);
    model_reset();
    @(posedge clock); #1 reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bit dslot;
      dslot = (i == 4);
      tick(1, 0, 10'(32'h0C0 + 4 * i), 32'h0, 1, 10'(32'h0E0 + 4 * i),
           !dslot, dslot, $sformatf("post_rst%0d", i));
    end
    idle("post_rst_idle");

    // Debug-only for 70000 cycles from a fresh reset: debug counter saturates
    @(negedge clock);
    cpuReq = 1'b0; dbgReq = 1'b0;
    reset = 1'b1;
    model_reset();
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    dbgReq = 1'b1; dbgAddress = 10'h000;
    repeat (70000) @(posedge clock);
    @(negedge clock);
    dbgReq = 1'b0;
    #1;
    chk("sat.dbgCount", {16'b0, dbgCount}, 32'h0000FFFF);
    chk("sat.cpuCount", {16'b0, cpuCount}, 32'h0);
    chk("sat.dbgGrant", {31'b0, dbgGrant}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
